// File: rtl/ntt_pkg.sv
// Shared NTT datapath constants: coefficient width, modulus and the largest supported stage.
// No logic, so no latency or backpressure.
package ntt_pkg;

    localparam int                    DATA_WIDTH = 23;
    localparam logic [DATA_WIDTH-1:0] Q          = 23'd8380417;
    localparam int                    MAX_STAGE  = 7;

endpackage

// File: rtl/ntt_pair_buffer_delay_ram.sv
// Simple dual-port delay memory with one write port, one registered read port and no reset.
// Read data appears 1 cycle after i_rd_en and holds until the next read. There is no backpressure.
module delay_ram #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 23,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [WIDTH-1:0] o_rd_dat
);

    // Sized to the full address space so a 1-deep instance still has a legal 1-bit index.
    localparam int NWORDS = 1 << AW;

    logic [WIDTH-1:0] r_mem [NWORDS];
    logic [WIDTH-1:0] r_rd_dat;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule

// File: rtl/ntt_pair_buffer.sv
// Reorders a coefficient stream into butterfly operand pairs (x[j], x[j+2^STAGE]).
// Each pair appears 1 cycle after its second-half word is accepted. There is no backpressure.
module ntt_pair_buffer
    import ntt_pkg::*;
#(
    parameter int STAGE = 7
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic                       in_first,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       out_valid,
    output logic                       out_last,
    output logic [1:0][DATA_WIDTH-1:0] out,
    output logic                       sync_err
);

    localparam int DIST = 1 << STAGE;
    localparam int AW   = (STAGE > 0) ? STAGE : 1;

    logic [STAGE:0]          r_idx;
    logic                    r_out_vld;
    logic                    r_out_last;
    logic                    r_sync_err;
    logic                    r_have_pair;
    logic [DATA_WIDTH-1:0]   r_hi_dat;

    logic [STAGE:0]          w_eidx;
    logic                    w_second_half;
    logic                    w_wr_en;
    logic                    w_rd_en;
    logic [AW-1:0]           w_addr;
    logic [DATA_WIDTH-1:0]   w_rd_dat;
    logic [DATA_WIDTH-1:0]   w_lo_dat;

    // An accepted in_first always restarts the block at index 0.
    assign w_eidx        = (in_valid && in_first) ? '0 : r_idx;
    assign w_second_half = w_eidx[STAGE];
    assign w_wr_en       = in_valid && !w_second_half;
    assign w_rd_en       = in_valid &&  w_second_half;

    generate
        if (STAGE == 0) begin : g_addr_single
            assign w_addr = '0;
        end else begin : g_addr_multi
            assign w_addr = w_eidx[AW-1:0];
        end
    endgenerate

    delay_ram #(
        .DEPTH (DIST),
        .WIDTH (DATA_WIDTH)
    ) u_delay_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_addr),
        .i_wr_dat  (in_data),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (w_addr),
        .o_rd_dat  (w_rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_out_vld   <= 1'b0;
            r_out_last  <= 1'b0;
            r_sync_err  <= 1'b0;
            r_have_pair <= 1'b0;
            r_hi_dat    <= '0;
        end else begin
            r_out_vld  <= w_rd_en;
            r_out_last <= w_rd_en && (&w_eidx);
            if (in_valid) begin
                r_idx <= w_eidx + 1'b1;
            end
            if (in_valid && in_first && (r_idx != '0)) begin
                r_sync_err <= 1'b1;
            end
            if (w_rd_en) begin
                r_hi_dat    <= in_data;
                r_have_pair <= 1'b1;
            end
        end
    end

    // The RAM read register has no reset, so mask it until the first pair has been read.
    assign w_lo_dat  = r_have_pair ? w_rd_dat : '0;

    assign out_valid = r_out_vld;
    assign out_last  = r_out_last;
    assign out       = {r_hi_dat, w_lo_dat};
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_ntt_pair_buffer.sv
// Three pair buffers (STAGE 0, 2, 7) share one input stream; each has its own block-list model and monitor.
module tb_ntt_pair_buffer;
    import ntt_pkg::*;

    typedef struct {
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  last;
    } pair_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_first;
    logic [DATA_WIDTH-1:0] in_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int stage,
                         input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s stage=%0d actual=%0h expected=%0h t=%0t", name, stage, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int S = (g == 0) ? 0 : ((g == 1) ? 2 : 7);
        localparam int D = 1 << S;

        logic                       o_vld;
        logic                       o_last;
        logic                       o_err;
        logic [1:0][DATA_WIDTH-1:0] o_pair;

        ntt_pair_buffer #(.STAGE(S)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_first  (in_first),
            .in_data   (in_data),
            .out_valid (o_vld),
            .out_last  (o_last),
            .out       (o_pair),
            .sync_err  (o_err)
        );

        logic [DATA_WIDTH-1:0] blk [$];
        pair_t                 exp_q [$];
        logic                  exp_err = 1'b0;
        logic [DATA_WIDTH-1:0] hold_a  = '0;
        logic [DATA_WIDTH-1:0] hold_b  = '0;

        // Reference: keep the words of the current block; a word past the first half pairs with the word D before it.
        always @(posedge clk or negedge rst_n) begin : model
            pair_t np;
            if (!rst_n) begin
                blk.delete();
                exp_q.delete();
                exp_err = 1'b0;
            end else if (in_valid) begin
                if (in_first) begin
                    if (blk.size() != 0) exp_err = 1'b1;
                    blk.delete();
                end
                blk.push_back(in_data);
                if (blk.size() > D) begin
                    np.a    = blk[blk.size() - 1 - D];
                    np.b    = in_data;
                    np.last = (blk.size() == 2 * D);
                    exp_q.push_back(np);
                end
                if (blk.size() == 2 * D) blk.delete();
            end
        end

        always @(negedge clk) begin : monitor
            pair_t p;
            logic  ev;
            if (!rst_n) begin
                hold_a = '0;
                hold_b = '0;
                check("rst_out_valid", S, 64'(o_vld), 64'(1'b0));
                check("rst_out_last",  S, 64'(o_last), 64'(1'b0));
                check("rst_out0",      S, 64'(o_pair[0]), 64'(0));
                check("rst_out1",      S, 64'(o_pair[1]), 64'(0));
                check("rst_sync_err",  S, 64'(o_err), 64'(1'b0));
            end else begin
                ev = (exp_q.size() != 0);
                check("out_valid", S, 64'(o_vld), 64'(ev));
                if (ev) begin
                    p      = exp_q.pop_front();
                    hold_a = p.a;
                    hold_b = p.b;
                    check("out_last", S, 64'(o_last), 64'(p.last));
                end else begin
                    check("out_last_idle", S, 64'(o_last), 64'(1'b0));
                end
                check("out0",     S, 64'(o_pair[0]), 64'(hold_a));
                check("out1",     S, 64'(o_pair[1]), 64'(hold_b));
                check("sync_err", S, 64'(o_err), 64'(exp_err));
            end
        end
    end

    task automatic send(input logic v, input logic f, input logic [DATA_WIDTH-1:0] d);
        in_valid = v;
        in_first = f;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles carry random in_first/in_data, which must be ignored without in_valid.
    task automatic idle(input int n);
        repeat (n) send(1'b0, 1'($urandom_range(0, 1)), DATA_WIDTH'($urandom));
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        send(1'b0, 1'b0, '0);
        rst_n = 1'b1;
    endtask

    initial begin
        int   w;
        logic v;
        logic f;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Two back-to-back 256-word blocks counting down from Q-1.
        for (int i = 0; i < 512; i++) send(1'b1, (i % 256) == 0, DATA_WIDTH'(Q - 1 - i));
        idle(3);

        // 0..7 continuous.
        for (int i = 0; i < 8; i++) send(1'b1, i == 0, DATA_WIDTH'(i));
        idle(3);

        // 0..7 with in_valid toggling.
        for (int i = 0; i < 8; i++) begin
            send(1'b1, i == 0, DATA_WIDTH'(i));
            send(1'b0, 1'b0, DATA_WIDTH'($urandom));
        end
        idle(3);

        // 10..13, pairs of neighbours at STAGE 0.
        for (int i = 0; i < 4; i++) send(1'b1, i == 0, DATA_WIDTH'(10 + i));
        idle(3);

        // in_first on the third word of a block.
        send(1'b1, 1'b1, DATA_WIDTH'(100));
        send(1'b1, 1'b0, DATA_WIDTH'(101));
        for (int i = 0; i < 8; i++) send(1'b1, i == 0, DATA_WIDTH'(200 + i));
        idle(3);

        // Reset in the middle of the second half; next block starts without in_first.
        for (int i = 0; i < 5; i++) send(1'b1, i == 0, DATA_WIDTH'(300 + i));
        pulse_reset();
        for (int i = 0; i < 8; i++) send(1'b1, 1'b0, DATA_WIDTH'(400 + i));
        idle(3);

        // Random traffic: gaps, mostly aligned in_first, occasional misplaced ones, one mid-run reset.
        w = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                pulse_reset();
                w = 0;
            end
            v = ($urandom_range(0, 3) != 0);
            if (w % 8 == 0) f = 1'($urandom_range(0, 1));
            else            f = ($urandom_range(0, 59) == 0);
            send(v, f, DATA_WIDTH'($urandom_range(0, int'(Q))));
            if (v) w = (f) ? 1 : w + 1;
        end
        idle(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ntt_pair_buffer.md
# ntt_pair_buffer

Streaming reorder stage placed directly upstream of the `add_sub` butterfly in each NTT/INTT pipeline stage. Accepts one coefficient per cycle and emits, once per coefficient of the second half of each block, the operand pair `(x[j], x[j+DIST])` with `DIST = 2^STAGE`, aligned for the butterfly's `in[0]`/`in[1]` inputs. A `DIST`-deep delay memory holds the first half of each `2*DIST` block until its partners arrive.

## Interface
- `STAGE`, default 7: log2 of pair distance; `DIST = 2^STAGE`, block length `2*DIST`; legal range 0..7.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_first`  in  1  qualified by `in_valid`; marks coefficient 0 of a block.
- `in_data`  in  `DATA_WIDTH`  coefficient, 0..Q.
- `out_valid`  out  1  `out` holds a valid pair.
- `out_last`  out  1  with `out_valid`; last pair of the block.
- `out`  out  `[DATA_WIDTH-1:0] [2]`  `out[0]` = x[j], `out[1]` = x[j+DIST].
- `sync_err`  out  1  sticky; `in_first` was seen while `idx != 0`.

## Operation
- Block index counter `idx` (STAGE+1 bits) counts accepted words 0..2*DIST-1. It advances only on `in_valid` and wraps from 2*DIST-1 to 0.
- Effective index `e = (in_valid && in_first) ? 0 : idx`. After an accepted word, `idx <= e + 1` (mod 2*DIST).
- First half (`e[STAGE] == 0`):
  - write `in_data` to the delay memory at address `e[STAGE-1:0]`;
  - no output.
- Second half (`e[STAGE] == 1`):
  - read the delay memory at address `e[STAGE-1:0]`;
  - present `out[0]` = stored word, `out[1]` = `in_data`;
  - `out_last` = (`e == 2*DIST-1`).
- `STAGE == 0`: the memory is a single register with the address ignored, and even/odd words pair up.
- Resync: when `in_first` is accepted while `idx != 0`:
  - set `sync_err`, which is cleared only by reset;
  - the partially filled block is discarded with no output;
  - the new block starts at index 0.
- Gaps: `in_valid` low holds all state. Pairing is by word count, not by cycle. There is no backpressure, and the downstream butterfly always accepts.
- Data passes through unmodified. There is no modular arithmetic or width change.

## Timing
- Latency: the pair for second-half word j appears with `out_valid` high exactly 1 cycle after that word is accepted.
- Reads are synchronous. Write and read never target the same cycle/address, because a read of address a occurs DIST accepted words after its write.
- Throughput: DIST pairs per 2*DIST accepted words. Back-to-back blocks need no idle cycles.
- Reset values:
  - `out_valid`, `out_last`, `sync_err` = 0;
  - `out[0]`, `out[1]` = 0;
  - `idx` = 0.
- Delay memory contents are not reset.
- Reset asserted mid-block: the block is abandoned, and the next accepted word is index 0 regardless of `in_first`.
- `out_valid` is low in every cycle that does not follow an accepted second-half word. `out` holds its last value when `out_valid` is low.

## Structure
- `ntt_pkg` supplies `DATA_WIDTH` and `Q` and adds `MAX_STAGE = 7`. No new typedefs are needed.
- Sub-module `delay_ram #(DEPTH, WIDTH)`: simple dual-port, one write port, one registered read port, no reset. `ntt_pair_buffer` instantiates it with `DEPTH = DIST`.
- The index counter and output registers live in `ntt_pair_buffer`.

## Test plan
- STAGE=2, reset, then feed 0..7 with `in_valid` continuous and `in_first` on word 0 -> pairs (0,4),(1,5),(2,6),(3,7) on 4 consecutive cycles, starting 1 cycle after word 4 is accepted; `out_last` only with (3,7).
- STAGE=2, same data with `in_valid` toggling 1,0,1,0… -> same 4 pairs, each 1 cycle after its second word; `out_valid` never high on consecutive cycles.
- STAGE=0, stream 10,11,12,13 -> pairs (10,11),(12,13), each with `out_last`=1.
- STAGE=7, two back-to-back 256-word blocks of Q-1,Q-2,… -> 256 pairs total with correct partners; exactly two `out_last` pulses; no gap between blocks.
- STAGE=2, `in_first` asserted on the 3rd word of a block -> `sync_err`=1 and stays 1; no pairs from the aborted words; the following 8 words pair correctly.
- STAGE=2, `rst_n` low for 1 cycle after 5 words (mid second half) -> all outputs 0 during reset; the next 8 words form a clean block with no stale pairs.
